// File: rtl/txpause_gate.sv
// rtl/txpause_gate.sv - TX pause gate between user AXIS stream and XGMII encoder
//
// Holds off new frames at frame boundaries while the link partner requests
// pause. Frames already in flight always complete. Counts paused cycles and
// the number of times a frame was held.
//
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   cfg_tx_pause_enable         1 = honour rx_pause_active
//   rx_pause_active             pause request from the RX pause decoder
//   tdata_i/tkeep_i/tvalid_i/tlast_i/tuser_i, tready_o   upstream AXIS
//   tdata_o/tkeep_o/tvalid_o/tlast_o/tuser_o, tready_i   downstream AXIS
//   stat_clear                  zeroes both statistics counters
//   pause_cycles_o              saturating count of cycles spent paused
//   paused_frames_o             saturating count of idle->paused entries
//   pause_state_o               1 while paused
module txpause_gate #(
    parameter int CNT_W = 32,
    parameter int FRM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_tx_pause_enable,
    input  logic             rx_pause_active,
    input  logic [63:0]      tdata_i,
    input  logic [7:0]       tkeep_i,
    input  logic             tvalid_i,
    input  logic             tlast_i,
    input  logic             tuser_i,
    output logic             tready_o,
    output logic [63:0]      tdata_o,
    output logic [7:0]       tkeep_o,
    output logic             tvalid_o,
    output logic             tlast_o,
    output logic             tuser_o,
    input  logic             tready_i,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] pause_cycles_o,
    output logic [FRM_W-1:0] paused_frames_o,
    output logic             pause_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRAME  = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic gate;
    logic accept;
    logic pop;
    logic room;

    // Two-entry skid: beat = {tuser, tlast, tkeep, tdata}
    logic [73:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    assign gate = cfg_tx_pause_enable & rx_pause_active;

    // Room comes from registered occupancy only, so tready_o never depends
    // combinationally on tready_i. Occupancy 1 with a pop each cycle still
    // sustains one beat per cycle.
    assign room   = (count != 2'd2);
    assign accept = tvalid_i & tready_o;
    assign pop    = tvalid_o & tready_i;

    always_comb begin
        state_nxt = state;
        tready_o  = 1'b0;
        case (state)
            S_IDLE: begin
                // At a frame boundary the gate wins over a waiting first beat.
                if (gate) begin
                    state_nxt = S_PAUSED;
                end else begin
                    tready_o = room;
                    if (tvalid_i && room && !tlast_i) begin
                        state_nxt = S_FRAME;
                    end
                end
            end
            S_FRAME: begin
                tready_o = room;
                if (tvalid_i && room && tlast_i) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PAUSED: begin
                // Release goes through S_IDLE, so the first beat is taken
                // no earlier than the cycle after the gate drops.
                if (!gate) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (rst) begin
            tready_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while tvalid_o=1.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {tuser_i, tlast_i, tkeep_i, tdata_i};
        end
    end

    assign tvalid_o = (count != 2'd0);
    assign {tuser_o, tlast_o, tkeep_o, tdata_o} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            pause_cycles_o  <= '0;
            paused_frames_o <= '0;
        end else begin
            if (state == S_PAUSED && pause_cycles_o != {CNT_W{1'b1}}) begin
                pause_cycles_o <= pause_cycles_o + CNT_W'(1);
            end
            if (state == S_IDLE && gate && paused_frames_o != {FRM_W{1'b1}}) begin
                paused_frames_o <= paused_frames_o + FRM_W'(1);
            end
        end
    end

    assign pause_state_o = (state == S_PAUSED);

endmodule
